fetch_stage: RTL

Instruction-fetch stage of the five-stage MIPS pipeline: the consumer end of the exception-redirect interface (`exc_bus`/`cancel`) that the write-back stage drives.
- Holds the architectural fetch PC and issues one instruction-memory request at a time over a variable-latency req/ack handshake.
- Hands each fetched {pc, inst} pair to decode.
- Applies redirects with fixed priority: exception/eret redirect first, then branch/jump target from decode, then sequential PC+4.
- Discards in-flight or held instructions when a redirect occurs.

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one memory request at a time,
// and hands {pc, inst} to decode, honouring exception, branch and sequential redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ID_allowin,
    input  logic [32:0] jbr_bus,
    input  logic [32:0] exc_bus,
    input  logic        cancel,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic        IF_ID_valid,
    output logic [63:0] IF_ID_bus,
    output logic        IF_over,
    output logic [31:0] IF_pc
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   inst_q, inst_d;
    logic [AW-1:0]   jbr_tgt_q, jbr_tgt_d;
    logic            jbr_pend_q, jbr_pend_d;

    logic            exc_valid;
    logic [AW-1:0]   exc_pc;
    logic            jbr_taken;
    logic [AW-1:0]   jbr_target;
    logic            flush;
    logic [AW-1:0]   redir_pc;
    logic            handoff;
    logic [AW-1:0]   next_pc;

    assign exc_valid  = exc_bus[32];
    assign exc_pc     = exc_bus[31:0];
    assign jbr_taken  = jbr_bus[32];
    assign jbr_target = jbr_bus[31:0];

    // Exception redirect outranks a bare cancel, which simply refetches pc_q.
    assign flush    = exc_valid | cancel;
    assign redir_pc = exc_valid ? exc_pc : pc_q;
    assign handoff  = (state_q == S_HOLD) & ID_allowin & ~flush;

    // A branch reported in the handoff cycle wins over an older pending one.
    assign next_pc = jbr_taken  ? jbr_target :
                     jbr_pend_q ? jbr_tgt_q  : pc_q + AW'(4);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:  state_d = flush ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (inst_ack) begin
                    state_d = flush ? S_REQ : S_HOLD;
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush || ID_allowin) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (inst_ack) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Outputs; everything is held quiet while reset is asserted
    always_comb begin
        inst_req    = 1'b0;
        IF_ID_valid = 1'b0;
        IF_over     = 1'b0;
        IF_ID_bus   = 64'd0;
        inst_addr   = RESET_PC;
        IF_pc       = RESET_PC;
        if (resetn) begin
            inst_req    = (state_q == S_REQ);
            IF_ID_valid = (state_q == S_HOLD);
            IF_over     = handoff;
            IF_ID_bus   = {pc_q, inst_q};
            inst_addr   = pc_q;
            IF_pc       = pc_q;
        end
    end

    // PC, captured instruction and pending-branch next values
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        jbr_pend_d = jbr_pend_q;
        jbr_tgt_d  = jbr_tgt_q;

        if (flush) begin
            pc_d = redir_pc;
        end else if (handoff) begin
            pc_d = next_pc;
        end

        if ((state_q == S_WAIT) && inst_ack && !flush) begin
            inst_d = inst_rdata;
        end

        if (flush || handoff) begin
            jbr_pend_d = 1'b0;
        end else if (jbr_taken) begin
            jbr_pend_d = 1'b1;
            jbr_tgt_d  = jbr_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q       <= RESET_PC;
            inst_q     <= 32'd0;
            jbr_pend_q <= 1'b0;
            jbr_tgt_q  <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            jbr_pend_q <= jbr_pend_d;
            jbr_tgt_q  <= jbr_tgt_d;
        end
    end

endmodule
